// File: rtl/request_slot_scheduler.sv
// request_slot_scheduler: DEPTH-slot request register with round-robin selection of occupied slots.
// Defining SCHED_DUP_FILTER_EN drops loads whose code already sits in an occupied slot.
module request_slot_scheduler #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [WIDTH-1:0]           IN,
    input  logic                       LOAD,
    input  logic                       RCO,
    input  logic                       SERVED,
    output logic [WIDTH-1:0]           OUT,
    output logic [$clog2(DEPTH)-1:0]   SEL,
    output logic                       VALID,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       FULL,
    output logic                       OVERFLOW
);
    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [WIDTH-1:0] slot_d [DEPTH];
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic             ovf_q;
    logic             ovf_d;

    logic [DEPTH-1:0] occ_q;
    logic [DEPTH-1:0] occ_clr;
    logic [SEL_W-1:0] free_idx;
    logic             free_found;
    logic             rco_found;
    logic             load_req;
    logic             dup_hit;
    logic             do_write;
    logic [CNT_W-1:0] count;

    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int step);
        int t;
        t = int'(base) + step;
        if (t >= DEPTH) begin
            t = t - DEPTH;
        end
        return t[SEL_W-1:0];
    endfunction

    // occ_clr is occupancy after the same-cycle SERVED clear; both the RCO search and the load use it
    always_comb begin
        occ_q   = '0;
        occ_clr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_q[i]   = (slot_q[i] != '0);
            occ_clr[i] = occ_q[i] && !(SERVED && (sel_q == SEL_W'(i)));
        end
    end

    always_comb begin
        sel_d     = sel_q;
        rco_found = 1'b0;
        if (RCO) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (!rco_found && occ_clr[wrap_add(sel_q, k)]) begin
                    sel_d     = wrap_add(sel_q, k);
                    rco_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!free_found && !occ_clr[i]) begin
                free_idx   = SEL_W'(i);
                free_found = 1'b1;
            end
        end
    end

`ifdef SCHED_DUP_FILTER_EN
    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ_clr[i] && (slot_q[i] == IN)) begin
                dup_hit = 1'b1;
            end
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    assign load_req = LOAD && (IN != '0) && !dup_hit;
    assign do_write = load_req && free_found;
    assign ovf_d    = load_req && !free_found;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
        end
        if (SERVED) begin
            slot_d[sel_q] = '0;
        end
        if (do_write) begin
            slot_d[free_idx] = IN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            sel_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            sel_q <= sel_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(occ_q[i]);
        end
    end

    assign OUT      = slot_q[sel_q];
    assign SEL      = sel_q;
    assign VALID    = |occ_q;
    assign COUNT    = count;
    assign FULL     = (count == CNT_W'(DEPTH));
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_request_slot_scheduler.sv
// Bench for request_slot_scheduler: reference model feeds a scoreboard queue, plus directed checks.
module tb_request_slot_scheduler;
    localparam int D = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] IN = '0;
    logic       LOAD = 1'b0;
    logic       RCO = 1'b0;
    logic       SERVED = 1'b0;
    logic [7:0] OUT;
    logic [1:0] SEL;
    logic       VALID;
    logic [2:0] COUNT;
    logic       FULL;
    logic       OVERFLOW;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] out;
        logic [1:0] sel;
        logic [2:0] count;
        logic       full;
        logic       valid;
        logic       ovf;
    } exp_t;

    exp_t       sb_q [$];
    logic [7:0] m_slot [D];
    logic [1:0] m_sel;

    always #5 CLK = ~CLK;

    request_slot_scheduler #(.WIDTH(8), .DEPTH(D)) dut (
        .CLK(CLK), .RESET(RESET), .IN(IN), .LOAD(LOAD), .RCO(RCO), .SERVED(SERVED),
        .OUT(OUT), .SEL(SEL), .VALID(VALID), .COUNT(COUNT), .FULL(FULL), .OVERFLOW(OVERFLOW)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_slot[i] = '0;
        m_sel = '0;
    endtask

    task automatic cycle(input logic ld, input logic [7:0] din, input logic rco, input logic srv);
        exp_t e;
        logic ovf;
        logic dup;
        int   free;
        int   cnt;
        @(negedge CLK);
        LOAD = ld; IN = din; RCO = rco; SERVED = srv;
        if (srv) m_slot[m_sel] = '0;
        if (rco) begin
            for (int k = 1; k < D; k++) begin
                if (m_slot[(int'(m_sel) + k) % D] != 0) begin
                    m_sel = 2'((int'(m_sel) + k) % D);
                    break;
                end
            end
        end
        ovf = 1'b0;
        dup = 1'b0;
        if (ld && din != 0) begin
`ifdef SCHED_DUP_FILTER_EN
            for (int i = 0; i < D; i++) if (m_slot[i] == din) dup = 1'b1;
`endif
            free = -1;
            for (int i = 0; i < D; i++) if (free < 0 && m_slot[i] == 0) free = i;
            if (!dup) begin
                if (free >= 0) m_slot[free] = din;
                else ovf = 1'b1;
            end
        end
        cnt = 0;
        for (int i = 0; i < D; i++) if (m_slot[i] != 0) cnt++;
        e.out = m_slot[m_sel]; e.sel = m_sel; e.count = 3'(cnt);
        e.full = (cnt == D); e.valid = (cnt != 0); e.ovf = ovf;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        chk("sb_out", OUT, e.out);
        chk("sb_sel", SEL, e.sel);
        chk("sb_count", COUNT, e.count);
        chk("sb_full", FULL, e.full);
        chk("sb_valid", VALID, e.valid);
        chk("sb_ovf", OVERFLOW, e.ovf);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1; LOAD = 0; RCO = 0; SERVED = 0; IN = '0;
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] wrap_out [4];
        logic [7:0] pick [5];
        wrap_out[0] = 8'h04; wrap_out[1] = 8'h10; wrap_out[2] = 8'h80; wrap_out[3] = 8'h01;
        pick[0] = 8'h00; pick[1] = 8'h01; pick[2] = 8'h02; pick[3] = 8'h04; pick[4] = 8'h08;
        model_reset();
        #1 RESET = 1'b1;
        #1;
        chk("rst_out", OUT, 0);
        chk("rst_sel", SEL, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_full", FULL, 0);
        chk("rst_ovf", OVERFLOW, 0);
        @(negedge CLK);
        RESET = 1'b0;
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("idle_sel", SEL, 0);

        cycle(1, 8'h01, 0, 0);
        cycle(1, 8'h04, 0, 0);
        cycle(1, 8'h10, 0, 0);
        cycle(1, 8'h80, 0, 0);
        chk("fill_count", COUNT, 4);
        chk("fill_full", FULL, 1);
        chk("fill_out", OUT, 8'h01);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'h00, 1, 0);
            chk("wrap_out", OUT, wrap_out[i]);
            chk("wrap_sel", SEL, (i + 1) % 4);
        end

        cycle(0, 8'h00, 1, 1);
        chk("skip_sel", SEL, 1);
        chk("skip_out", OUT, 8'h04);
        chk("skip_count", COUNT, 3);
        cycle(1, 8'h20, 0, 0);
        chk("refill_count", COUNT, 4);
        cycle(1, 8'h40, 0, 0);
        chk("ovf_pulse", OVERFLOW, 1);
        cycle(0, 8'h00, 0, 0);
        chk("ovf_clear", OVERFLOW, 0);
        cycle(0, 8'h00, 1, 0);
        chk("slot0_reuse_sel", SEL, 2);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("slot0_refilled", OUT, 8'h20);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("at_sel2", SEL, 2);

        cycle(1, 8'h08, 0, 1);
        chk("srvld_out", OUT, 8'h08);
        chk("srvld_count", COUNT, 4);
        chk("srvld_ovf", OVERFLOW, 0);
        chk("srvld_sel", SEL, 2);

        do_reset();
        cycle(1, 8'h00, 0, 0);
        chk("zero_load", COUNT, 0);
        cycle(1, 8'h04, 0, 0);
        cycle(1, 8'h04, 0, 0);
`ifdef SCHED_DUP_FILTER_EN
        chk("dup_count", COUNT, 1);
`else
        chk("dup_count", COUNT, 2);
`endif
        cycle(0, 8'h00, 1, 0);
        cycle(1, 8'h11, 0, 0);

        @(negedge CLK);
        IN = 8'h55; LOAD = 1'b1; RCO = 1'b1; SERVED = 1'b0;
        #2 RESET = 1'b1;
        #1;
        chk("arst_out", OUT, 0);
        chk("arst_count", COUNT, 0);
        chk("arst_valid", VALID, 0);
        chk("arst_sel", SEL, 0);
        @(posedge CLK);
        #1;
        chk("arst_hold", COUNT, 0);
        @(negedge CLK);
        LOAD = 1'b0; RCO = 1'b0; IN = '0; RESET = 1'b0;
        model_reset();
        cycle(0, 8'h00, 0, 0);
        chk("arst_noload", COUNT, 0);
        cycle(1, 8'h33, 0, 0);
        chk("post_arst_out", OUT, 8'h33);

        for (int n = 0; n < 60; n++) begin
            cycle(1'($urandom_range(0, 1)), pick[$urandom_range(0, 4)],
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
